// File: rtl/time_set_ctrl.sv
// Seconds-of-day counter with button-driven set mode and a blink phase for the field being edited.
// Optional idle auto-exit from set mode is enabled by defining SET_TIMEOUT_EN.
module time_set_ctrl #(
    parameter int CNT_W         = 20,
    parameter int BLINK_CYCLES  = 25_000_000,
    parameter int TIMEOUT_TICKS = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick_1hz,
    input  logic             btn_mode,
    input  logic             btn_inc,
    input  logic             btn_dec,
    output logic [CNT_W-1:0] cnt_o,
    output logic [1:0]       mode_o,
    output logic             blink_o
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        SET_H = 2'd1,
        SET_M = 2'd2,
        SET_S = 2'd3
    } state_t;

    localparam int DIV_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(BLINK_CYCLES - 1);
    localparam logic [CNT_W-1:0] SEC_PER_H = CNT_W'(3600);
    localparam logic [CNT_W-1:0] SEC_PER_M = CNT_W'(60);

    state_t           state;
    state_t           state_n;
    logic [4:0]       hh;
    logic [4:0]       hh_n;
    logic [5:0]       mm;
    logic [5:0]       mm_n;
    logic [5:0]       ss;
    logic [5:0]       ss_n;
    logic [DIV_W-1:0] div;
    logic             adjust_up;
    logic             adjust_down;
    logic             any_btn;

    function automatic logic [5:0] wrap_up(input logic [5:0] v, input logic [5:0] top);
        return (v == top) ? 6'd0 : v + 6'd1;
    endfunction

    function automatic logic [5:0] wrap_down(input logic [5:0] v, input logic [5:0] top);
        return (v == 6'd0) ? top : v - 6'd1;
    endfunction

    // Simultaneous inc and dec cancel; a mode press swallows both.
    assign adjust_up   = btn_inc && !btn_dec && !btn_mode;
    assign adjust_down = btn_dec && !btn_inc && !btn_mode;
    assign any_btn     = btn_mode || btn_inc || btn_dec;
    assign mode_o      = state;

`ifdef SET_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_TICKS - 1);

    logic [TO_W-1:0] to_cnt;
    logic            timeout_hit;

    assign timeout_hit = (state != RUN) && tick_1hz && !any_btn && (to_cnt == TO_LAST);
`endif

    always_comb begin
        state_n = state;
        hh_n    = hh;
        mm_n    = mm;
        ss_n    = ss;
        case (state)
            RUN: begin
                if (tick_1hz) begin
                    if (ss == 6'd59) begin
                        ss_n = 6'd0;
                        if (mm == 6'd59) begin
                            mm_n = 6'd0;
                            hh_n = (hh == 5'd23) ? 5'd0 : hh + 5'd1;
                        end else begin
                            mm_n = mm + 6'd1;
                        end
                    end else begin
                        ss_n = ss + 6'd1;
                    end
                end
                if (btn_mode) state_n = SET_H;
            end
            SET_H: begin
                if (btn_mode) state_n = SET_M;
                if (adjust_up)   hh_n = 5'(wrap_up({1'b0, hh}, 6'd23));
                if (adjust_down) hh_n = 5'(wrap_down({1'b0, hh}, 6'd23));
            end
            SET_M: begin
                if (btn_mode) state_n = SET_S;
                if (adjust_up)   mm_n = wrap_up(mm, 6'd59);
                if (adjust_down) mm_n = wrap_down(mm, 6'd59);
            end
            SET_S: begin
                if (btn_mode) state_n = RUN;
                if (adjust_up)   ss_n = wrap_up(ss, 6'd59);
                if (adjust_down) ss_n = wrap_down(ss, 6'd59);
            end
            default: state_n = RUN;
        endcase
`ifdef SET_TIMEOUT_EN
        if (timeout_hit) state_n = RUN;
`endif
    end

    // cnt_o is built from the registered fields, so it trails them by one clock.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= RUN;
            hh      <= 5'd0;
            mm      <= 6'd0;
            ss      <= 6'd0;
            cnt_o   <= '0;
            div     <= '0;
            blink_o <= 1'b0;
        end else begin
            state <= state_n;
            hh    <= hh_n;
            mm    <= mm_n;
            ss    <= ss_n;
            cnt_o <= CNT_W'(hh) * SEC_PER_H + CNT_W'(mm) * SEC_PER_M + CNT_W'(ss);
            if (state_n != state) begin
                div     <= '0;
                blink_o <= (state_n != RUN);
            end else if (state != RUN) begin
                if (div == DIV_LAST) begin
                    div     <= '0;
                    blink_o <= ~blink_o;
                end else begin
                    div <= div + 1'b1;
                end
            end
        end
    end

`ifdef SET_TIMEOUT_EN
    // Counts idle seconds while editing; any button press or state change restarts it.
    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt <= '0;
        end else if (state_n != state || any_btn || state == RUN) begin
            to_cnt <= '0;
        end else if (tick_1hz) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed and randomized bench for time_set_ctrl, checked against a time-of-day model.
// Timeout scenarios run only when SET_TIMEOUT_EN is defined.
module tb_time_set_ctrl;

    localparam int CNT_W   = 20;
    localparam int BLINK   = 4;
    localparam int TIMEOUT = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             tick_1hz = 1'b0;
    logic             btn_mode = 1'b0;
    logic             btn_inc = 1'b0;
    logic             btn_dec = 1'b0;
    logic [CNT_W-1:0] cnt_o;
    logic [1:0]       mode_o;
    logic             blink_o;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    // Reference model: time of day as hours/minutes/seconds, mode number,
    // cycles spent in the current mode and idle seconds in set mode.
    int m_h = 0, m_m = 0, m_s = 0, m_mode = 0, m_cyc = 0, m_idle = 0;
    int exp_total = 0;

    time_set_ctrl #(
        .CNT_W(CNT_W),
        .BLINK_CYCLES(BLINK),
        .TIMEOUT_TICKS(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .tick_1hz(tick_1hz),
        .btn_mode(btn_mode),
        .btn_inc(btn_inc),
        .btn_dec(btn_dec),
        .cnt_o(cnt_o),
        .mode_o(mode_o),
        .blink_o(blink_o)
    );

    always #5 clk = ~clk;

    task automatic modelEdge(input logic r, input logic t, input logic md, input logic i, input logic d);
        int next_mode;
        int tod;
        exp_total = r ? 0 : m_h * 3600 + m_m * 60 + m_s;
        if (r) begin
            m_h = 0; m_m = 0; m_s = 0; m_mode = 0; m_cyc = 0; m_idle = 0;
            return;
        end
        next_mode = m_mode;
        if (m_mode == 0) begin
            if (t) begin
                tod = (m_h * 3600 + m_m * 60 + m_s + 1) % 86400;
                m_h = tod / 3600;
                m_m = (tod / 60) % 60;
                m_s = tod % 60;
            end
            if (md) next_mode = 1;
        end else begin
            if (md) next_mode = (m_mode + 1) % 4;
            else if (i && !d) begin
                if (m_mode == 1) m_h = (m_h + 1) % 24;
                if (m_mode == 2) m_m = (m_m + 1) % 60;
                if (m_mode == 3) m_s = (m_s + 1) % 60;
            end else if (d && !i) begin
                if (m_mode == 1) m_h = (m_h + 23) % 24;
                if (m_mode == 2) m_m = (m_m + 59) % 60;
                if (m_mode == 3) m_s = (m_s + 59) % 60;
            end
`ifdef SET_TIMEOUT_EN
            if (md || i || d) m_idle = 0;
            else if (t) begin
                m_idle++;
                if (m_idle == TIMEOUT) next_mode = 0;
            end
`endif
        end
        if (next_mode != m_mode) begin
            m_cyc = 0;
            m_idle = 0;
        end else begin
            m_cyc++;
        end
        m_mode = next_mode;
    endtask

    task automatic checkOutput();
        logic [CNT_W-1:0] e_cnt;
        logic [1:0]       e_mode;
        logic             e_blink;
        e_cnt   = CNT_W'(exp_total);
        e_mode  = 2'(m_mode);
        e_blink = (m_mode != 0) && (((m_cyc / BLINK) % 2) == 0);
        checks++;
        assert (cnt_o === e_cnt) passes++;
        else begin
            fails++;
            $error("[TB] FAIL cnt_o got %0d expected %0d", cnt_o, e_cnt);
        end
        checks++;
        assert (mode_o === e_mode) passes++;
        else begin
            fails++;
            $error("[TB] FAIL mode_o got %0d expected %0d", mode_o, e_mode);
        end
        checks++;
        assert (blink_o === e_blink) passes++;
        else begin
            fails++;
            $error("[TB] FAIL blink_o got %0b expected %0b", blink_o, e_blink);
        end
    endtask

    task automatic checkConst(input string tag, input logic [CNT_W-1:0] act, input logic [CNT_W-1:0] exp);
        checks++;
        assert (act === exp) passes++;
        else begin
            fails++;
            $error("[TB] FAIL %s got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic t, input logic md, input logic i, input logic d);
        rst = r; tick_1hz = t; btn_mode = md; btn_inc = i; btn_dec = d;
        modelEdge(r, t, md, i, d);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    initial begin
        // Reset held three cycles, then five ticks in RUN.
        repeat (3) applyStimulus(1, 0, 0, 0, 0);
        checkConst("reset_cnt", cnt_o, 0);
        applyStimulus(0, 0, 0, 0, 0);
        repeat (5) begin
            applyStimulus(0, 1, 0, 0, 0);
            applyStimulus(0, 0, 0, 0, 0);
        end
        checkConst("five_ticks", cnt_o, 5);

        // Edit fields from midnight: hour and minute wrap down without borrow.
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0);
        checkConst("set_h_dec", cnt_o, 82800);
        checkConst("mode_set_h", {18'd0, mode_o}, 1);
        applyStimulus(0, 0, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0);
        checkConst("set_m_dec", cnt_o, 86340);
        applyStimulus(0, 0, 1, 0, 0);
        applyStimulus(0, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 0);
        checkConst("set_s_inc2", cnt_o, 86342);
        checkConst("mode_set_s", {18'd0, mode_o}, 3);

        // Seconds to 59, ticks ignored while editing, then midnight rollover.
        repeat (3) applyStimulus(0, 0, 0, 0, 1);
        repeat (2) applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        checkConst("preset_max", cnt_o, 86399);
        applyStimulus(0, 0, 1, 0, 0);
        checkConst("back_to_run", {18'd0, mode_o}, 0);
        applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        checkConst("rollover", cnt_o, 0);

        // SET_M: ticks dropped, inc+dec cancel, mode+inc only advances.
        applyStimulus(0, 0, 1, 0, 0);
        applyStimulus(0, 0, 1, 0, 0);
        applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 1);
        applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(0, 0, 1, 1, 0);
        checkConst("mode_inc_adv", {18'd0, mode_o}, 3);
        applyStimulus(0, 0, 0, 0, 0);
        checkConst("set_m_hold", cnt_o, 0);
        applyStimulus(0, 0, 1, 0, 0);

        // Mode with tick in RUN: both take effect, then blink cadence in SET_H.
        applyStimulus(0, 1, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        checkConst("tick_with_mode", cnt_o, 1);
        repeat (10) applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 0, 0);
        checkConst("blink_restart", {19'd0, blink_o}, 1);
        applyStimulus(0, 0, 1, 0, 0);
        applyStimulus(0, 0, 1, 0, 0);
        checkConst("blink_run", {19'd0, blink_o}, 0);

`ifdef SET_TIMEOUT_EN
        // Idle timeout in SET_S restarts on the inc press and keeps the edit.
        applyStimulus(1, 0, 0, 0, 0);
        repeat (3) applyStimulus(0, 0, 1, 0, 0);
        repeat (2) applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 0);
        repeat (2) applyStimulus(0, 1, 0, 0, 0);
        checkConst("timeout_wait", {18'd0, mode_o}, 3);
        applyStimulus(0, 1, 0, 0, 0);
        checkConst("timeout_exit", {18'd0, mode_o}, 0);
        applyStimulus(0, 0, 0, 0, 0);
        checkConst("timeout_keep", cnt_o, 1);
`endif

        // Randomized traffic against the model.
        for (int n = 0; n < 600; n++) begin
            applyStimulus($urandom_range(0, 99) == 0,
                          $urandom_range(0, 2) == 0,
                          $urandom_range(0, 7) == 0,
                          $urandom_range(0, 3) == 0,
                          $urandom_range(0, 3) == 0);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
